// File: rtl/bbsweep_pkg.sv
// Shared types, constants and the signature step for breadboard sweep controllers.
package bbsweep_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam int unsigned VEC_COUNT = 16;
  localparam logic [3:0]  LAST_VEC  = 4'd15;
  localparam int unsigned SIG_W     = 16;

  // Rotate left by one, then fold in the (zero-extended) response.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] data);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ data;
  endfunction

endpackage

// File: rtl/bbsweep_sig.sv
// 16-bit rotate-XOR signature register with synchronous clear and enable.
module bbsweep_sig
  import bbsweep_pkg::*;
#(
  parameter int unsigned DataW = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DataW-1:0] data_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else if (clr_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= sig_step(sig_q, SIG_W'(data_i));
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/breadboard_sweep_ctrl.sv
// Drives all 16 breadboard input vectors, captures and signs each response.
// Optional golden-response checking is enabled by defining BBSWEEP_CHECK_EN.
module breadboard_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RESP_W        = 10,
  parameter int unsigned SIG_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [3:0]        stim,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              cap_valid,
  output logic [3:0]        cap_index,
  output logic [RESP_W-1:0] cap_data,
  output logic [SIG_W-1:0]  sig
`ifdef BBSWEEP_CHECK_EN
  ,
  input  logic [RESP_W-1:0] exp_data,
  output logic [4:0]        mismatch_cnt,
  output logic              fail,
  output logic [3:0]        first_fail
`endif
);
  import bbsweep_pkg::*;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        stim_q, stim_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              sig_clr, cap_en;
  logic              cap_valid_q;
  logic [3:0]        cap_index_q;
  logic [RESP_W-1:0] cap_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    sig_clr = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          stim_d  = '0;
          cnt_d   = '0;
          sig_clr = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          stim_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCapture: begin
        // Abort discards this capture entirely: no cap_valid, no signature fold.
        if (abort) begin
          stim_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cap_en = 1'b1;
          if (stim_q == LAST_VEC) begin
            state_d = StDone;
          end else begin
            stim_d  = stim_q + 4'd1;
            state_d = StSettle;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
      cap_index_q <= '0;
      cap_data_q  <= '0;
    end else begin
      cap_valid_q <= cap_en;
      if (cap_en) begin
        cap_index_q <= stim_q;
        cap_data_q  <= resp;
      end
    end
  end

  bbsweep_sig #(
    .DataW (RESP_W)
  ) u_sig (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (sig_clr),
    .en_i   (cap_en),
    .data_i (resp),
    .sig_o  (sig)
  );

`ifdef BBSWEEP_CHECK_EN
  logic [4:0] mismatch_cnt_q;
  logic       fail_q;
  logic [3:0] first_fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_cnt_q <= '0;
      fail_q         <= 1'b0;
      first_fail_q   <= '0;
    end else if (sig_clr) begin
      mismatch_cnt_q <= '0;
      fail_q         <= 1'b0;
      first_fail_q   <= '0;
    end else if (cap_en && (resp != exp_data)) begin
      mismatch_cnt_q <= mismatch_cnt_q + 5'd1;
      if (!fail_q) begin
        fail_q       <= 1'b1;
        first_fail_q <= stim_q;
      end
    end
  end

  assign mismatch_cnt = mismatch_cnt_q;
  assign fail         = fail_q;
  assign first_fail   = first_fail_q;
`endif

  assign stim      = stim_q;
  assign busy      = (state_q == StSettle) || (state_q == StCapture);
  assign done      = (state_q == StDone);
  assign cap_valid = cap_valid_q;
  assign cap_index = cap_index_q;
  assign cap_data  = cap_data_q;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed bench for breadboard_sweep_ctrl: one DUT at S=2, one at S=1 on a breadboard model.
module tb_breadboard_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, start2, abort2, busy2, done2, capv2;
  logic [3:0] stim2, capi2;
  logic [9:0] resp2, capd2;
  logic [15:0] sig2;
  logic       rst1, start1, abort1, busy1, done1, capv1;
  logic [3:0] stim1, capi1;
  logic [9:0] resp1, capd1;
  logic [15:0] sig1;

  logic [9:0] resp_const;
  bit         chk_mode;

  int checks = 0;
  int failures = 0;

  // Stand-in for the breadboard: 10 distinct combinational functions of {w,x,y,z}.
  function automatic logic [9:0] bb_logic(input logic [3:0] v);
    logic w, x, y, z;
    {w, x, y, z} = v;
    return {w & x, x | y, y ^ z, ~(w | z), w ^ x ^ y ^ z,
            (w & y) | z, ~x, x & y & z, w | ~y, (v == 4'd9)};
  endfunction

  function automatic logic [15:0] sig_model(input logic [15:0] s, input logic [9:0] r);
    return {s[14:0], s[15]} ^ {6'b0, r};
  endfunction

  always_comb resp2 = resp_const;
  always_comb resp1 = bb_logic(stim1);

`ifdef BBSWEEP_CHECK_EN
  logic [9:0] exp2, exp1;
  logic [4:0] mm2, mm1;
  logic       fail2, fail1;
  logic [3:0] ff2, ff1;
  always_comb exp2 = (chk_mode && (stim2 == 4'd5 || stim2 == 4'd12)) ? ~resp_const : resp_const;
  always_comb exp1 = resp1;
`endif

  breadboard_sweep_ctrl #(.SETTLE_CYCLES(2), .RESP_W(10), .SIG_W(16)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .abort(abort2), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .cap_valid(capv2), .cap_index(capi2), .cap_data(capd2),
    .sig(sig2)
`ifdef BBSWEEP_CHECK_EN
    , .exp_data(exp2), .mismatch_cnt(mm2), .fail(fail2), .first_fail(ff2)
`endif
  );

  breadboard_sweep_ctrl #(.SETTLE_CYCLES(1), .RESP_W(10), .SIG_W(16)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .cap_valid(capv1), .cap_index(capi1), .cap_data(capd1),
    .sig(sig1)
`ifdef BBSWEEP_CHECK_EN
    , .exp_data(exp1), .mismatch_cnt(mm1), .fail(fail1), .first_fail(ff1)
`endif
  );

  // Observation record filled by watch(); cycle n is the n-th cycle after start acceptance.
  int          w_idx[$];
  int          w_cyc[$];
  logic [9:0]  w_data[$];
  logic [15:0] w_sig[$];
  int          w_done_at, w_done_cnt, w_busy_first, w_busy_last, w_busy_cnt, w_stim_bad;
  logic [3:0]  w_stim[0:127];

  task automatic start_pulse(input bit d1);
    @(negedge clk);
    if (d1) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Records DUT activity for ncyc cycles; raises abort during cycle abort_at (0 = never).
  task automatic watch(input bit d1, input int s, input int ncyc, input int abort_at);
    w_idx.delete(); w_cyc.delete(); w_data.delete(); w_sig.delete();
    w_done_at = -1; w_done_cnt = 0; w_busy_first = -1; w_busy_last = -1;
    w_busy_cnt = 0; w_stim_bad = 0;
    for (int n = 1; n <= ncyc; n++) begin
      logic b, cv, dn;
      logic [3:0] st, ci;
      logic [9:0] cd;
      logic [15:0] sg;
      b  = d1 ? busy1 : busy2;
      cv = d1 ? capv1 : capv2;
      dn = d1 ? done1 : done2;
      st = d1 ? stim1 : stim2;
      ci = d1 ? capi1 : capi2;
      cd = d1 ? capd1 : capd2;
      sg = d1 ? sig1 : sig2;
      if (n < 128) w_stim[n] = st;
      if (b) begin
        if (w_busy_first < 0) w_busy_first = n;
        w_busy_last = n;
        w_busy_cnt++;
        if (int'(st) != (n - 1) / (s + 1)) w_stim_bad++;
      end
      if (cv) begin
        w_idx.push_back(int'(ci));
        w_cyc.push_back(n);
        w_data.push_back(cd);
        w_sig.push_back(sg);
      end
      if (dn) begin
        w_done_cnt++;
        w_done_at = n;
      end
      if (d1) abort1 = (n == abort_at); else abort2 = (n == abort_at);
      @(negedge clk);
    end
    abort1 = 1'b0;
    abort2 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1;
    start1 = 1'b0; start2 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    resp_const = '0; chk_mode = 1'b0;
    #2;
    checks++;
    if ({stim2, busy2, done2, capv2, capi2, capd2, sig2} !== 40'h0) begin
      failures++;
      $display("FAIL reset_dut2: got %h expected 0",
               {stim2, busy2, done2, capv2, capi2, capd2, sig2});
    end
    checks++;
    if ({stim1, busy1, done1, capv1, capi1, capd1, sig1} !== 40'h0) begin
      failures++;
      $display("FAIL reset_dut1: got %h expected 0",
               {stim1, busy1, done1, capv1, capi1, capd1, sig1});
    end
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_resp();
    resp_const = 10'h000;
    start_pulse(1'b0);
    watch(1'b0, 2, 55, 0);
    checks++;
    if (w_idx.size() != 16) begin
      failures++; $display("FAIL zero_cap_count: got %0d expected 16", w_idx.size());
    end
    foreach (w_idx[k]) begin
      checks++;
      if (w_idx[k] != k || w_cyc[k] != (k + 1) * 3 + 1) begin
        failures++;
        $display("FAIL zero_cap_%0d: got idx %0d at cycle %0d expected idx %0d at cycle %0d",
                 k, w_idx[k], w_cyc[k], k, (k + 1) * 3 + 1);
      end
    end
    checks++;
    if (w_done_at != 49 || w_done_cnt != 1) begin
      failures++;
      $display("FAIL zero_done: got cycle %0d count %0d expected cycle 49 count 1",
               w_done_at, w_done_cnt);
    end
    checks++;
    if (sig2 !== 16'h0000) begin
      failures++; $display("FAIL zero_sig: got %h expected 0000", sig2);
    end
    checks++;
    if (w_busy_first != 1 || w_busy_last != 48 || w_busy_cnt != 48) begin
      failures++;
      $display("FAIL zero_busy: got %0d..%0d (%0d) expected 1..48 (48)",
               w_busy_first, w_busy_last, w_busy_cnt);
    end
    checks++;
    if (w_stim_bad != 0 || stim2 !== 4'd15) begin
      failures++;
      $display("FAIL zero_stim: got %0d bad cycles, final stim %0d expected 0 and 15",
               w_stim_bad, stim2);
    end
  endtask

  task automatic test_sig_ones();
    logic [15:0] e;
    resp_const = 10'h001;
    start_pulse(1'b0);
    watch(1'b0, 2, 55, 0);
    e = 16'h0000;
    checks++;
    if (w_sig.size() != 16) begin
      failures++; $display("FAIL ones_cap_count: got %0d expected 16", w_sig.size());
    end
    foreach (w_sig[k]) begin
      e = sig_model(e, 10'h001);
      checks++;
      if (w_sig[k] !== e || w_data[k] !== 10'h001) begin
        failures++;
        $display("FAIL ones_sig_%0d: got sig %h data %h expected sig %h data 001",
                 k, w_sig[k], w_data[k], e);
      end
    end
    checks++;
    if (sig2 !== 16'hFFFF) begin
      failures++; $display("FAIL ones_final_sig: got %h expected ffff", sig2);
    end
  endtask

  task automatic test_breadboard();
    logic [15:0] e;
    logic [3:0]  kv;
    start_pulse(1'b1);
    watch(1'b1, 1, 40, 0);
    e = 16'h0000;
    checks++;
    if (w_done_at != 33 || w_idx.size() != 16) begin
      failures++;
      $display("FAIL bb_done: got cycle %0d caps %0d expected cycle 33 caps 16",
               w_done_at, w_idx.size());
    end
    foreach (w_idx[k]) begin
      kv = 4'(k);
      e  = sig_model(e, bb_logic(kv));
      checks++;
      if (w_idx[k] != k || w_data[k] !== bb_logic(kv) || w_cyc[k] != (k + 1) * 2 + 1) begin
        failures++;
        $display("FAIL bb_cap_%0d: got idx %0d data %h cycle %0d expected idx %0d data %h cycle %0d",
                 k, w_idx[k], w_data[k], w_cyc[k], k, bb_logic(kv), (k + 1) * 2 + 1);
      end
    end
    checks++;
    if (w_stim_bad != 0) begin
      failures++; $display("FAIL bb_stim_stable: got %0d bad cycles expected 0", w_stim_bad);
    end
    checks++;
    if (sig1 !== e) begin
      failures++; $display("FAIL bb_sig: got %h expected %h", sig1, e);
    end
  endtask

  task automatic test_abort();
    logic [15:0] e;
    resp_const = 10'h2A5;
    start_pulse(1'b0);
    watch(1'b0, 2, 30, 10);
    e = sig_model(sig_model(sig_model(16'h0, 10'h2A5), 10'h2A5), 10'h2A5);
    checks++;
    if (w_idx.size() != 3) begin
      failures++; $display("FAIL abort_cap_count: got %0d expected 3", w_idx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (w_idx[k] != k) begin
          failures++; $display("FAIL abort_cap_%0d: got idx %0d expected %0d", k, w_idx[k], k);
        end
      end
    end
    checks++;
    if (w_done_cnt != 0 || w_busy_last != 10 || w_stim[11] !== 4'd0) begin
      failures++;
      $display("FAIL abort_stop: got done %0d busy_last %0d stim@11 %0d expected 0 10 0",
               w_done_cnt, w_busy_last, w_stim[11]);
    end
    checks++;
    if (sig2 !== e) begin
      failures++; $display("FAIL abort_partial_sig: got %h expected %h", sig2, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    start_pulse(1'b0);
    watch(1'b0, 2, 55, 0);
    e = 16'h0000;
    for (int k = 0; k < 16; k++) e = sig_model(e, 10'h2A5);
    checks++;
    if (w_sig.size() != 16 || w_done_at != 49) begin
      failures++;
      $display("FAIL b2b_sweep: got caps %0d done %0d expected 16 49", w_sig.size(), w_done_at);
    end else begin
      checks++;
      if (w_sig[0] !== 16'h02A5) begin
        failures++; $display("FAIL b2b_first_sig: got %h expected 02a5", w_sig[0]);
      end
    end
    checks++;
    if (sig2 !== e) begin
      failures++; $display("FAIL b2b_final_sig: got %h expected %h", sig2, e);
    end
  endtask

  task automatic test_start_held_reset();
    resp_const = 10'h000;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    watch(1'b0, 2, 19, 0);
    checks++;
    if (w_busy_cnt != 19 || w_idx.size() != 6 || w_done_cnt != 0 || w_stim_bad != 0) begin
      failures++;
      $display("FAIL held_start: got busy %0d caps %0d done %0d bad %0d expected 19 6 0 0",
               w_busy_cnt, w_idx.size(), w_done_cnt, w_stim_bad);
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if ({stim2, busy2, done2, capv2, capi2, capd2, sig2} !== 40'h0) begin
      failures++;
      $display("FAIL midsweep_reset: got %h expected 0",
               {stim2, busy2, done2, capv2, capi2, capd2, sig2});
    end
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    start2 = 1'b0;
    watch(1'b0, 2, 55, 0);
    checks++;
    if (w_busy_first != 1 || w_stim[1] !== 4'd0 || w_done_at != 49 || w_idx.size() != 16) begin
      failures++;
      $display("FAIL post_reset_sweep: got busy_first %0d stim %0d done %0d caps %0d expected 1 0 49 16",
               w_busy_first, w_stim[1], w_done_at, w_idx.size());
    end
  endtask

`ifdef BBSWEEP_CHECK_EN
  task automatic test_check();
    chk_mode = 1'b1;
    resp_const = 10'h155;
    start_pulse(1'b0);
    watch(1'b0, 2, 55, 0);
    checks++;
    if (mm2 !== 5'd2 || ff2 !== 4'd5 || fail2 !== 1'b1) begin
      failures++;
      $display("FAIL check_mismatch: got cnt %0d first %0d fail %0d expected 2 5 1",
               mm2, ff2, fail2);
    end
    chk_mode = 1'b0;
    start_pulse(1'b0);
    watch(1'b0, 2, 55, 0);
    checks++;
    if (mm2 !== 5'd0 || ff2 !== 4'd0 || fail2 !== 1'b0) begin
      failures++;
      $display("FAIL check_clear: got cnt %0d first %0d fail %0d expected 0 0 0",
               mm2, ff2, fail2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_resp();
    test_sig_ones();
    test_breadboard();
    test_abort();
    test_back_to_back();
    test_start_held_reset();
`ifdef BBSWEEP_CHECK_EN
    test_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
